// File: rtl/gen_frecv_pkg.sv
// gen_frecv_pkg
//   Shared definitions for the square-wave generator:
//   - state_t      : controller state encoding (IDLE / DIV / APPLY)
//   - FMIN, FMAX   : accepted frequency range in Hz
//   - clog2()      : ceiling log2, used to size the divider datapath
package gen_frecv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam int FMIN = 1;
  localparam int FMAX = 9999;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gen_frecv_div_rest.sv
// div_rest
//   Sequential unsigned restoring divider with a constant dividend.
//   One quotient bit per cycle, MSB first, DIV_W cycles per division.
// Ports:
//   clk       system clock (posedge)
//   reset     synchronous active-low reset, aborts a running division
//   start     load divisor and begin a division (ignored bits: none)
//   divisor   DIV_W-bit unsigned divisor, sampled when start is high
//   quotient  floor(DIVIDEND / divisor), valid when done pulses
//   done      one-cycle pulse after the last quotient bit is produced
module div_rest
  import gen_frecv_pkg::*;
#(
  parameter int               DIV_W    = 25,
  parameter logic [DIV_W-1:0] DIVIDEND = DIV_W'(25000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int IDX_W = clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_reg;
  logic [DIV_W-1:0] quot_reg;
  logic [DIV_W-1:0] dsr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             run_reg;
  logic             done_reg;

  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   diff;
  logic             fits;

  // quot_reg starts as the dividend and is shifted left each step: its MSB
  // feeds the partial remainder while the new quotient bit enters at the LSB.
  // Because rem < divisor, rem_sh < 2*divisor, so the MSB of the
  // difference is a clean borrow flag: clear means rem_sh >= divisor.
  always_comb begin
    rem_sh = {rem_reg, quot_reg[DIV_W-1]};
    diff   = rem_sh - {1'b0, dsr_reg};
    fits   = ~diff[DIV_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_reg  <= '0;
      quot_reg <= '0;
      dsr_reg  <= '0;
      idx_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        dsr_reg  <= divisor;
        rem_reg  <= '0;
        quot_reg <= DIVIDEND;
        idx_reg  <= IDX_W'(DIV_W - 1);
        run_reg  <= 1'b1;
      end else if (run_reg) begin
        rem_reg  <= fits ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
        quot_reg <= {quot_reg[DIV_W-2:0], fits};
        if (idx_reg == '0) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg - IDX_W'(1);
        end
      end
    end
  end

  assign quotient = quot_reg;
  assign done     = done_reg;

endmodule

// File: rtl/gen_frecv.sv
// gen_frecv
//   Square-wave generator driven by a frequency selector. A validated
//   frequency strobe starts a divider computing the half-period in clock
//   cycles; a free-running counter toggles out_frecv every half-period.
// Ports:
//   clk        system clock (posedge)
//   reset      synchronous active-low reset
//   frecv_sel  requested frequency in Hz (valid while q_modif is high)
//   q_modif    update strobe
//   out_frecv  50 % duty square wave
//   frecv_act  frequency currently applied to out_frecv
//   busy       high while a division is in progress
//   err        last strobe carried a value outside FMIN..FMAX
module gen_frecv #(
  parameter int width  = 16,
  parameter int CLK_HZ = 50000000,
  parameter int FMAX   = gen_frecv_pkg::FMAX,
  parameter int DIV_W  = gen_frecv_pkg::clog2(CLK_HZ / 2 + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] frecv_sel,
  input  logic             q_modif,
  output logic             out_frecv,
  output logic [width-1:0] frecv_act,
  output logic             busy,
  output logic             err
);

  import gen_frecv_pkg::*;

  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(CLK_HZ / 2);
  localparam logic [width-1:0] FMIN_W   = width'(gen_frecv_pkg::FMIN);
  localparam logic [width-1:0] FMAX_W   = width'(FMAX);

  state_t           state_reg, state_next;
  logic [width-1:0] cur_div_reg;
  logic [width-1:0] pend_val_reg;
  logic             pending_reg;
  logic [width-1:0] frecv_act_reg;
  logic [DIV_W-1:0] half_per_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic             out_reg;
  logic             err_reg;

  logic             in_range;
  logic             strobe_ok;
  logic             start;
  logic [width-1:0] div_sel;
  logic [DIV_W-1:0] quotient;
  logic             div_done;

  assign in_range  = (frecv_sel >= FMIN_W) && (frecv_sel <= FMAX_W);
  assign strobe_ok = q_modif && in_range;

  div_rest #(
    .DIV_W   (DIV_W),
    .DIVIDEND(HALF_RST)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .divisor (DIV_W'(div_sel)),
    .quotient(quotient),
    .done    (div_done)
  );

  // Next state and divider launch.
  // In APPLY a strobe arriving in that very cycle is newer than anything
  // queued, so it is divided directly; otherwise a queued value is used.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    div_sel    = frecv_sel;
    case (state_reg)
      IDLE: begin
        if (strobe_ok) begin
          start      = 1'b1;
          state_next = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (strobe_ok) begin
          start      = 1'b1;
          state_next = DIV;
        end else if (pending_reg) begin
          start      = 1'b1;
          div_sel    = pend_val_reg;
          state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cur_div_reg   <= '0;
      pend_val_reg  <= '0;
      pending_reg   <= 1'b0;
      frecv_act_reg <= width'(1);
      half_per_reg  <= HALF_RST;
      cnt_reg       <= '0;
      out_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start) begin
        cur_div_reg <= div_sel;
      end

      // Valid strobes are always accepted or queued, so err just follows
      // the range check of the most recent strobe.
      if (q_modif) begin
        err_reg <= !in_range;
      end

      case (state_reg)
        DIV: begin
          if (strobe_ok) begin
            pending_reg  <= 1'b1;
            pend_val_reg <= frecv_sel;
          end
        end
        APPLY: begin
          // Whatever was queued is consumed here (or superseded by a
          // strobe in this cycle, which is launched directly).
          pending_reg   <= 1'b0;
          half_per_reg  <= (quotient == '0) ? DIV_W'(1) : quotient;
          frecv_act_reg <= cur_div_reg;
        end
        default: ;
      endcase

      // Using >= lets a shortened half-period take effect immediately
      // without the counter having to wrap through its full range.
      if (cnt_reg >= half_per_reg - DIV_W'(1)) begin
        cnt_reg <= '0;
        out_reg <= ~out_reg;
      end else begin
        cnt_reg <= cnt_reg + DIV_W'(1);
      end
    end
  end

  assign out_frecv = out_reg;
  assign frecv_act = frecv_act_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;

endmodule

// File: tb/tb_gen_frecv.sv
// tb_gen_frecv
//   Self-checking bench for gen_frecv at CLK_HZ=20000 (half-period
//   10000/f cycles). Inputs driven and outputs sampled on negedge.
module tb_gen_frecv;

  localparam int CLK_HZ = 20000;
  localparam int LAT    = 16;     // strobe edge to frecv_act update

  logic        clk;
  logic        reset;
  logic [15:0] frecv_sel;
  logic        q_modif;
  logic        out_frecv;
  logic [15:0] frecv_act;
  logic        busy;
  logic        err;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_act;

  gen_frecv #(
    .width (16),
    .CLK_HZ(CLK_HZ),
    .FMAX  (9999)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .frecv_sel(frecv_sel),
    .q_modif  (q_modif),
    .out_frecv(out_frecv),
    .frecv_act(frecv_act),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: half-period is floor((CLK_HZ/2)/f), never below 1.
  function automatic int model_half(input int f);
    int h;
    h = (CLK_HZ / 2) / f;
    return (h < 1) ? 1 : h;
  endfunction

  // One-cycle strobe; called and returns on a negedge.
  task automatic strobe(input logic [15:0] v);
    frecv_sel = v;
    q_modif   = 1'b1;
    @(negedge clk);
    q_modif   = 1'b0;
    $display("[TB] strobe frecv_sel=%0d busy=%0b err=%0b frecv_act=%0d", v, busy, err, frecv_act);
  endtask

  // Cycles between two consecutive toggles of out_frecv, -1 on timeout.
  task automatic half_period(output int n);
    logic last;
    int   w;
    n    = -1;
    last = out_frecv;
    w    = 0;
    while (out_frecv === last && w < 25000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 25000) return;
    last = out_frecv;
    w    = 0;
    while (out_frecv === last && w < 25000) begin
      @(negedge clk);
      w++;
    end
    if (w < 25000) n = w;
  endtask

  task automatic test_reset();
    int w;
    // Strobe with an invalid value during reset must be ignored.
    reset     = 1'b0;
    q_modif   = 1'b1;
    frecv_sel = 16'd0;
    repeat (3) @(negedge clk);
    q_modif = 1'b0;
    tests_run++;
    if (out_frecv !== 1'b0) begin tests_failed++; $display("FAIL rst_out: got %0b expected 0", out_frecv); end
    tests_run++;
    if (frecv_act !== 16'd1) begin tests_failed++; $display("FAIL rst_act: got %0d expected 1", frecv_act); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0b expected 0", err); end
    exp_act = 16'd1;
    reset   = 1'b1;
    w = 0;
    while (out_frecv === 1'b0 && w < 12000) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (w !== 10000) begin tests_failed++; $display("FAIL rst_first_toggle: got %0d expected 10000", w); end
    $display("[TB] reset: first toggle after %0d cycles", w);
  endtask

  // Valid strobe: busy next edge, frecv_act updates exactly LAT edges later.
  task automatic test_apply(input string nm, input logic [15:0] f, input bit measure);
    int n;
    strobe(f);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy_next: got %0b expected 1", nm, busy); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL %s_err: got %0b expected 0", nm, err); end
    repeat (LAT - 1) @(negedge clk);
    tests_run++;
    if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL %s_act_early: got %0d expected %0d", nm, frecv_act, exp_act); end
    @(negedge clk);
    exp_act = f;
    tests_run++;
    if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL %s_act: got %0d expected %0d", nm, frecv_act, exp_act); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy_done: got %0b expected 0", nm, busy); end
    if (measure) begin
      half_period(n);
      tests_run++;
      if (n !== model_half(int'(f))) begin tests_failed++; $display("FAIL %s_half: got %0d expected %0d", nm, n, model_half(int'(f))); end
      $display("[TB] %s f=%0d half=%0d", nm, f, n);
    end
  endtask

  task automatic test_invalid();
    logic [15:0] bad [2];
    bad[0] = 16'd0;
    bad[1] = 16'd10000;
    for (int i = 0; i < 2; i++) begin
      strobe(bad[i]);
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_%0d: got %0b expected 1", bad[i], err); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL inv_busy_%0d: got %0b expected 0", bad[i], busy); end
      repeat (LAT + 2) @(negedge clk);
      tests_run++;
      if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL inv_act_%0d: got %0d expected %0d", bad[i], frecv_act, exp_act); end
    end
    test_apply("valid5", 16'd5, 1'b0);
  endtask

  // 50 at k=0, 200 at k=2, 400 at k=5: 50 applied, 200 discarded, 400 applied.
  task automatic test_back_to_back();
    logic [15:0] prev;
    logic [15:0] want;
    logic        want_busy;
    prev = exp_act;
    for (int k = 0; k < 36; k++) begin
      q_modif   = (k == 0 || k == 2 || k == 5);
      frecv_sel = (k == 0) ? 16'd50 : (k == 2) ? 16'd200 : 16'd400;
      @(negedge clk);
      want      = (k < LAT) ? prev : (k < 2 * LAT) ? 16'd50 : 16'd400;
      want_busy = (k < 2 * LAT);
      tests_run++;
      if (frecv_act !== want) begin tests_failed++; $display("FAIL b2b_act_k%0d: got %0d expected %0d", k, frecv_act, want); end
      tests_run++;
      if (busy !== want_busy) begin tests_failed++; $display("FAIL b2b_busy_k%0d: got %0b expected %0b", k, busy, want_busy); end
    end
    q_modif = 1'b0;
    exp_act = 16'd400;
    $display("[TB] back_to_back: frecv_act=%0d", frecv_act);
  endtask

  task automatic test_random();
    logic [15:0] f;
    logic [15:0] bad;
    for (int i = 0; i < 6; i++) begin
      f = (i == 0) ? 16'd9999 : 16'($urandom_range(20, 9999));
      test_apply("rand", f, 1'b1);
      bad = 16'($urandom_range(10000, 65535));
      strobe(bad);
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL rand_bad_err: got %0b expected 1 (v=%0d)", err, bad); end
      repeat (LAT + 2) @(negedge clk);
      tests_run++;
      if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL rand_bad_act: got %0d expected %0d", frecv_act, exp_act); end
    end
  endtask

  // A shorter half-period must take effect on the edge after APPLY.
  task automatic test_fast_apply();
    logic o;
    int   w;
    test_apply("f1", 16'd1, 1'b0);
    o = out_frecv;
    w = 0;
    while (out_frecv === o && w < 25000) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (w >= 25000) begin tests_failed++; $display("FAIL fast_wait_toggle: got timeout expected toggle"); end
    repeat (4984) @(negedge clk);
    strobe(16'd1000);
    o = out_frecv;
    repeat (LAT) @(negedge clk);
    exp_act = 16'd1000;
    tests_run++;
    if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL fast_act: got %0d expected %0d", frecv_act, exp_act); end
    tests_run++;
    if (out_frecv !== o) begin tests_failed++; $display("FAIL fast_no_toggle_at_apply: got %0b expected %0b", out_frecv, o); end
    @(negedge clk);
    tests_run++;
    if (out_frecv !== ~o) begin tests_failed++; $display("FAIL fast_toggle_after_apply: got %0b expected %0b", out_frecv, ~o); end
    $display("[TB] fast_apply: out_frecv=%0b", out_frecv);
  endtask

  task automatic test_reset_mid_div();
    int w;
    strobe(16'd200);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_act = 16'd1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL middiv_busy: got %0b expected 0", busy); end
    tests_run++;
    if (frecv_act !== exp_act) begin tests_failed++; $display("FAIL middiv_act: got %0d expected 1", frecv_act); end
    tests_run++;
    if (out_frecv !== 1'b0) begin tests_failed++; $display("FAIL middiv_out: got %0b expected 0", out_frecv); end
    reset = 1'b1;
    // Counter restarts from 0: with f=100 applied early, the first toggle
    // lands 100 edges after the reset edge.
    strobe(16'd100);
    w = 1;
    while (out_frecv === 1'b0 && w < 12000) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (w !== 100) begin tests_failed++; $display("FAIL middiv_cnt_restart: got %0d expected 100", w); end
    tests_run++;
    if (frecv_act !== 16'd100) begin tests_failed++; $display("FAIL middiv_reapply: got %0d expected 100", frecv_act); end
    $display("[TB] reset_mid_div: first toggle after %0d cycles", w);
  endtask

  initial begin
    reset     = 1'b0;
    q_modif   = 1'b0;
    frecv_sel = 16'd0;
    exp_act   = 16'd1;
    @(negedge clk);
    test_reset();
    test_apply("single100", 16'd100, 1'b1);
    test_apply("trunc3", 16'd3, 1'b1);
    test_invalid();
    test_back_to_back();
    test_random();
    test_fast_apply();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gen_frecv.md
Name: gen_frecv

Overview:
- Downstream consumer of the frequency selector.
- Takes the accepted 16-bit frequency value (Hz) and its update strobe, and computes the half-period in clock cycles with a sequential restoring divider.
- Drives a 50 % duty square wave at the selected frequency, which feeds the output/buzzer pin.
- Reports the currently applied frequency, a busy flag and an out-of-range error.

Parameters:
- width, 16: width of the frequency input and of the applied-frequency output.
- CLK_HZ, 50000000: system clock frequency in Hz.
- FMAX, 9999: highest accepted frequency in Hz; FMIN is fixed at 1.
- DIV_W, clog2(CLK_HZ/2+1) (25 at default): dividend, quotient and counter width; also the number of divide cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- frecv_sel  in  width  requested frequency in Hz.
- q_modif  in  1  update strobe; frecv_sel is valid in any cycle where this is high.
- out_frecv  out  1  square-wave output.
- frecv_act  out  width  frequency currently applied to out_frecv.
- busy  out  1  high while a division is in progress.
- err  out  1  last strobe carried an out-of-range value.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, out_frecv=0, cnt=0, half_per=CLK_HZ/2, frecv_act=1, busy=0, err=0, pending=0. Reset applies in every state and aborts any division in progress.
- Range check on every strobe: the value is valid iff 1 <= frecv_sel <= FMAX.
  - Invalid: err<=1; no other state change.
  - Valid strobe that is accepted or queued: err<=0.
- State machine: IDLE, DIV, APPLY.
- IDLE: on q_modif with a valid value:
  - divisor<=frecv_sel, rem<=0, quotient<=CLK_HZ/2, bit index<=DIV_W-1.
  - busy<=1; go to DIV.
  - busy is therefore high in the cycle after the strobe.
- DIV: one restoring step per cycle, MSB first.
  - rem'={rem, dividend bit}; if rem'>=divisor, subtract and set the quotient bit to 1.
  - Exactly DIV_W cycles, then APPLY.
- APPLY (1 cycle):
  - half_per<=max(quotient,1); frecv_act<=divisor.
  - If pending: load pend_val as the new divisor, pending<=0, go to DIV with busy held at 1.
  - Otherwise busy<=0 and go to IDLE.
- Latency: frecv_act updates DIV_W+2 edges after the strobe edge.
- Strobe while busy (DIV or APPLY) with a valid value: pending<=1, pend_val<=frecv_sel. The latest strobe wins; earlier queued values are discarded.
- Strobe in the same cycle as reset: ignored.
- Quotient is floor(CLK_HZ/2 / f). The remainder is discarded, so the frequency error is at most one cycle per half-period.
- Output counter runs every cycle independent of the FSM:
  - If cnt >= half_per-1: cnt<=0 and out_frecv toggles.
  - Otherwise cnt<=cnt+1.
  - Using >= means a reduced half_per takes effect on the next cycle with no wrap-around; an increased half_per extends the current half-period.
- Arithmetic: all comparisons are unsigned, DIV_W bits wide; frecv_sel is zero-extended.

Decomposition:
- Package gen_frecv_pkg holds:
  - State encoding: IDLE=2'd0, DIV=2'd1, APPLY=2'd2.
  - FMIN=1, FMAX=9999.
  - Function clog2 used to derive DIV_W.
- One sub-module, div_rest: a sequential unsigned restoring divider.
  - Handshake: start/done, divisor input, constant dividend parameter, quotient output.
  - gen_frecv instantiates div_rest and owns the range check, pending register and output counter.

Test Plan (all run with CLK_HZ=20000, giving DIV_W=14 and half_per=10000/f):
- Reset then release -> out_frecv=0, frecv_act=1, busy=0, err=0; out_frecv toggles every 10000 cycles.
- q_modif=1 for one cycle with frecv_sel=100 -> busy=1 on the next edge; frecv_act=100 and busy=0 16 edges after the strobe; out_frecv period becomes 200 cycles.
- Strobe frecv_sel=3 -> half_per=3333 (truncated), period 6666 cycles.
- Strobe 0, then 10000 -> err=1 each time and frecv_act unchanged. A following strobe of 5 -> err=0, and frecv_act=5 after the division.
- Strobe 50, then 200 two cycles later, then 400 five cycles after the first -> frecv_act becomes 50 then 400; 200 is never applied; busy stays high continuously between the two results.
- At f=1 with cnt near 5000, strobe 1000 (half_per=10) -> out_frecv toggles on the cycle after APPLY. Asserting reset mid-DIV -> busy=0, frecv_act=1 and cnt=0 on the next edge.
